game_ctrl: RTL and testbench

//  Top-level game sequencer for the frogger UI/playfield. Owns the MENU/PLAYING/DEAD/WIN FSM.

---
 rtl/game_ctrl_if.sv | 12 +
 rtl/game_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_game_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/game_ctrl_if.sv
// game_ctrl_if: valid/ready link from the game sequencer to the shared sound player.
//   snd_valid  master->slave  request valid, held until accepted
//   snd_type   master->slave  0 UI_PRESS, 1 NEXTLEVEL, 2 CRASH, 3 CELEBRATION
//   snd_ready  slave->master  player accepts; transfer when snd_valid & snd_ready
interface game_ctrl_if;
  logic       snd_valid;
  logic [1:0] snd_type;
  logic       snd_ready;

  modport master (output snd_valid, output snd_type, input snd_ready);
  modport slave  (input snd_valid, input snd_type, output snd_ready);
endinterface

// File: rtl/game_ctrl.sv
// game_ctrl: top-level frogger game sequencer.
// Owns the MENU/PLAYING/DEAD/WIN FSM. Tracks row progress, score, hi-score and level.
// Issues sound-effect requests over a valid/ready link that has a one-deep priority pending slot.
//   clk, rst       system clock, synchronous active-high reset
//   btn_*_tick     1-cycle button pulses (up, down, any)
//   collision      frog hit a hazard (level, only honoured while PLAYING)
//   state          0 MENU, 1 PLAYING, 2 DEAD, 3 WIN
//   level, score,  registered ui_gen display values
//   hiscore
//   snd            sound request link (master side)
//
// state   | meaning
// MENU    | idle, waiting for any button to start a game
// PLAYING | frog moving, collision and goal checks active
// DEAD    | crashed; buttons blocked until hold timer expires
// WIN     | cleared final level; buttons blocked until hold timer expires
module game_ctrl #(
  parameter int GOAL_ROWS   = 12,
  parameter int MAX_LEVEL   = 9,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int SCORE_MAX   = 999
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_up_tick,
  input  logic               btn_down_tick,
  input  logic               btn_any_tick,
  input  logic               collision,
  output logic [1:0]         state,
  output logic [3:0]         level,
  output logic [9:0]         score,
  output logic [9:0]         hiscore,
  game_ctrl_if.master        snd
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_MENU    = 2'd0,
    S_PLAYING = 2'd1,
    S_DEAD    = 2'd2,
    S_WIN     = 2'd3
  } state_t;

  // Type encoding doubles as priority: higher code wins the pending slot.
  localparam logic [1:0] SND_UI_PRESS    = 2'd0;
  localparam logic [1:0] SND_NEXTLEVEL   = 2'd1;
  localparam logic [1:0] SND_CRASH       = 2'd2;
  localparam logic [1:0] SND_CELEBRATION = 2'd3;

  state_t              state_q, state_d;
  logic [3:0]          level_q, level_d;
  logic [9:0]          score_q, score_d;
  logic [9:0]          hiscore_q, hiscore_d;
  logic [3:0]          row_q, row_d;
  logic [3:0]          max_row_q, max_row_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                snd_valid_q, snd_valid_d;
  logic [1:0]          snd_type_q, snd_type_d;
  logic                pend_valid_q, pend_valid_d;
  logic [1:0]          pend_type_q, pend_type_d;

  logic                req_valid;
  logic [1:0]          req_type;
  logic [4:0]          row_inc;
  logic [9:0]          score_inc;
  logic [9:0]          score_new;
  logic                xfer;
  logic                out_free;

  assign row_inc   = {1'b0, row_q} + 5'd1;
  assign score_inc = (score_q >= 10'(SCORE_MAX)) ? 10'(SCORE_MAX) : score_q + 10'd1;

  // Game FSM and playfield bookkeeping.
  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    score_d   = score_q;
    hiscore_d = hiscore_q;
    row_d     = row_q;
    max_row_d = max_row_q;
    hold_d    = hold_q;
    req_valid = 1'b0;
    req_type  = SND_UI_PRESS;
    score_new = score_q;

    unique case (state_q)
      S_MENU: begin
        if (btn_any_tick) begin
          state_d   = S_PLAYING;
          score_d   = '0;
          level_d   = 4'd1;
          row_d     = '0;
          max_row_d = '0;
          req_valid = 1'b1;
          req_type  = SND_UI_PRESS;
        end
      end

      S_PLAYING: begin
        if (collision) begin
          state_d   = S_DEAD;
          req_valid = 1'b1;
          req_type  = SND_CRASH;
          hiscore_d = (score_q > hiscore_q) ? score_q : hiscore_q;
          hold_d    = HOLD_W'(HOLD_CYCLES - 1);
        end else if (btn_up_tick && btn_down_tick) begin
          // Contradictory input: hold position.
        end else if (btn_up_tick) begin
          row_d = row_inc[3:0];
          if (row_inc > {1'b0, max_row_q}) begin
            max_row_d = row_inc[3:0];
            score_new = score_inc;
          end
          score_d = score_new;
          if (row_inc == 5'(GOAL_ROWS)) begin
            if (level_q < 4'(MAX_LEVEL)) begin
              level_d   = level_q + 4'd1;
              row_d     = '0;
              max_row_d = '0;
              req_valid = 1'b1;
              req_type  = SND_NEXTLEVEL;
            end else begin
              state_d   = S_WIN;
              req_valid = 1'b1;
              req_type  = SND_CELEBRATION;
              hiscore_d = (score_new > hiscore_q) ? score_new : hiscore_q;
              hold_d    = HOLD_W'(HOLD_CYCLES - 1);
            end
          end
        end else if (btn_down_tick) begin
          if (row_q != 4'd0) begin
            row_d = row_q - 4'd1;
          end
        end
      end

      S_DEAD, S_WIN: begin
        if (hold_q != '0) begin
          hold_d = hold_q - HOLD_W'(1);
        end else if (btn_any_tick) begin
          state_d = S_MENU;
        end
      end

      default: state_d = S_MENU;
    endcase
  end

  // Sound link: output register plus a one-deep pending slot.
  assign xfer     = snd_valid_q & snd.snd_ready;
  assign out_free = ~snd_valid_q | xfer;

  always_comb begin
    snd_valid_d  = snd_valid_q;
    snd_type_d   = snd_type_q;
    pend_valid_d = pend_valid_q;
    pend_type_d  = pend_type_q;

    // Drain first: a queued entry takes the freed output register.
    if (out_free) begin
      if (pend_valid_q) begin
        snd_valid_d  = 1'b1;
        snd_type_d   = pend_type_q;
        pend_valid_d = 1'b0;
      end else begin
        snd_valid_d = 1'b0;
      end
    end

    // Then place the new request; it sees the slot as it stands after the drain.
    if (req_valid) begin
      if (out_free && !pend_valid_q) begin
        snd_valid_d = 1'b1;
        snd_type_d  = req_type;
      end else if (!pend_valid_d || (req_type >= pend_type_d)) begin
        pend_valid_d = 1'b1;
        pend_type_d  = req_type;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_MENU;
      level_q      <= 4'd1;
      score_q      <= '0;
      hiscore_q    <= '0;
      row_q        <= '0;
      max_row_q    <= '0;
      hold_q       <= '0;
      snd_valid_q  <= 1'b0;
      snd_type_q   <= SND_UI_PRESS;
      pend_valid_q <= 1'b0;
      pend_type_q  <= SND_UI_PRESS;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      score_q      <= score_d;
      hiscore_q    <= hiscore_d;
      row_q        <= row_d;
      max_row_q    <= max_row_d;
      hold_q       <= hold_d;
      snd_valid_q  <= snd_valid_d;
      snd_type_q   <= snd_type_d;
      pend_valid_q <= pend_valid_d;
      pend_type_q  <= pend_type_d;
    end
  end

  assign state         = state_q;
  assign level         = level_q;
  assign score         = score_q;
  assign hiscore       = hiscore_q;
  assign snd.snd_valid = snd_valid_q;
  assign snd.snd_type  = snd_type_q;

endmodule

// File: tb/tb_game_ctrl.sv
module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up_tick, btn_down_tick, btn_any_tick, collision;
  logic [1:0] state;
  logic [3:0] level;
  logic [9:0] score, hiscore;

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0] exp_q[$];

  game_ctrl_if snd ();

  game_ctrl #(
    .GOAL_ROWS  (3),
    .MAX_LEVEL  (2),
    .HOLD_CYCLES(8),
    .SCORE_MAX  (999)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_up_tick  (btn_up_tick),
    .btn_down_tick(btn_down_tick),
    .btn_any_tick (btn_any_tick),
    .collision    (collision),
    .state        (state),
    .level        (level),
    .score        (score),
    .hiscore      (hiscore),
    .snd          (snd.master)
  );

  always #5 clk = ~clk;

  // Scoreboard: every accepted sound transfer is compared against the expected queue.
  always @(negedge clk) begin
    if (!rst && snd.snd_valid && snd.snd_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL snd_xfer: unexpected transfer type %0d, none expected", snd.snd_type);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if (snd.snd_type !== e)
          $display("FAIL snd_xfer: type %0d, expected %0d", snd.snd_type, e);
        else
          n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic up, input logic dn, input logic any, input logic col);
    btn_up_tick = up; btn_down_tick = dn; btn_any_tick = any; collision = col;
    tick();
    btn_up_tick = 0; btn_down_tick = 0; btn_any_tick = 0; collision = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    else n_pass++;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || snd.snd_valid) && k < 20) begin
      tick();
      k++;
    end
    n_checks++;
    if (exp_q.size() != 0 || snd.snd_valid !== 1'b0)
      $display("FAIL %s: %0d sounds outstanding, snd_valid=%0b, expected 0 and 0", name, exp_q.size(), snd.snd_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1; snd.snd_ready = 1;
    btn_up_tick = 0; btn_down_tick = 0; btn_any_tick = 0; collision = 0;
    tick(); tick();
    rst = 0;
    chk("reset_state", state, 0);
    chk("reset_level", level, 1);
    chk("reset_score", score, 0);
    chk("reset_hiscore", hiscore, 0);
    chk("reset_snd_valid", snd.snd_valid, 0);
  endtask

  task automatic test_start();
    exp_q.push_back(2'd0);
    pulse(0, 0, 1, 0);
    chk("start_state", state, 1);
    chk("start_level", level, 1);
    chk("start_score", score, 0);
    chk("start_snd_valid", snd.snd_valid, 1);
    chk("start_snd_type", snd.snd_type, 0);
    tick();
    chk("start_snd_deassert", snd.snd_valid, 0);
  endtask

  task automatic test_progress();
    pulse(1, 0, 0, 0);
    chk("up1_score", score, 1);
    pulse(1, 0, 0, 0);
    chk("up2_score", score, 2);
    exp_q.push_back(2'd1);
    pulse(1, 0, 0, 0);
    chk("goal_score", score, 3);
    chk("goal_level", level, 2);
    chk("goal_state", state, 1);
    drain("nextlevel_drain");
    pulse(0, 1, 0, 0);
    chk("down_row0_score", score, 3);
    chk("down_row0_state", state, 1);
    pulse(1, 0, 0, 0);
    chk("reup_score", score, 4);
    pulse(0, 1, 0, 0);
    pulse(1, 0, 0, 0);
    chk("revisit_score", score, 4);
    pulse(1, 1, 0, 0);
    chk("both_btn_score", score, 4);
  endtask

  task automatic test_win();
    // row 1 now; both-buttons press left it there.
    pulse(1, 0, 0, 0);
    chk("win_pre_score", score, 5);
    exp_q.push_back(2'd3);
    pulse(1, 0, 0, 0);
    chk("win_state", state, 3);
    chk("win_score", score, 6);
    chk("win_hiscore", hiscore, 6);
    chk("win_level", level, 2);
    for (int i = 0; i < 7; i++) begin
      pulse(0, 0, 1, 0);
      chk("win_hold_block", state, 3);
    end
    pulse(0, 0, 1, 0);
    chk("win_exit_state", state, 0);
    chk("menu_keeps_score", score, 6);
    chk("menu_keeps_level", level, 2);
    drain("win_drain");
  endtask

  task automatic test_collision();
    exp_q.push_back(2'd0);
    pulse(0, 0, 1, 0);
    chk("restart_score", score, 0);
    chk("restart_level", level, 1);
    pulse(1, 0, 0, 0);
    chk("col_pre_score", score, 1);
    exp_q.push_back(2'd2);
    pulse(1, 0, 0, 1);
    chk("col_state", state, 2);
    chk("col_score", score, 1);
    chk("col_hiscore_kept", hiscore, 6);
    repeat (8) tick();
    pulse(0, 0, 1, 0);
    chk("dead_exit_state", state, 0);
    drain("col_drain");
    pulse(1, 0, 0, 1);
    chk("menu_collision_state", state, 0);
    chk("menu_collision_snd", snd.snd_valid, 0);
  endtask

  task automatic test_backpressure();
    snd.snd_ready = 0;
    exp_q.push_back(2'd0);
    pulse(0, 0, 1, 0);
    chk("bp_ui_valid", snd.snd_valid, 1);
    pulse(1, 0, 0, 0);
    pulse(1, 0, 0, 0);
    pulse(1, 0, 0, 0);
    chk("bp_level", level, 2);
    chk("bp_held_type", snd.snd_type, 0);
    exp_q.push_back(2'd2);
    pulse(0, 0, 0, 1);
    chk("bp_dead_state", state, 2);
    chk("bp_held_valid", snd.snd_valid, 1);
    chk("bp_held_type2", snd.snd_type, 0);
    snd.snd_ready = 1;
    drain("bp_drain");
  endtask

  task automatic test_reset_mid();
    rst = 1; tick(); rst = 0;
    snd.snd_ready = 0;
    pulse(0, 0, 1, 0);
    pulse(1, 0, 0, 0);
    chk("mid_pre_valid", snd.snd_valid, 1);
    chk("mid_pre_score", score, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("mid_state", state, 0);
    chk("mid_level", level, 1);
    chk("mid_score", score, 0);
    chk("mid_hiscore", hiscore, 0);
    chk("mid_snd_valid", snd.snd_valid, 0);
    chk("mid_snd_type", snd.snd_type, 0);
    snd.snd_ready = 1;
    repeat (3) tick();
    chk("mid_no_stale_sound", snd.snd_valid, 0);
  endtask

  initial begin
    test_reset();
    test_start();
    test_progress();
    test_win();
    test_collision();
    test_backpressure();
    test_reset_mid();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
